// File: rtl/gps_epoch_sched_if.sv
// gps_epoch_sched_if: register-file side signals of the epoch scheduler.
// master = register file / test driver, slave = gps_epoch_sched.
interface gps_epoch_sched_if #(
    parameter int NSAT = 4
);
    logic                      run_req;
    logic                      commit;
    logic [NSAT:0]             commit_mask;
    logic                      err_clr;
    logic [NSAT-1:0][31:0]     shd_freq;
    logic [NSAT-1:0][15:0]     shd_gain;
    logic [NSAT-1:0][5:0]      shd_ca_sel;
    logic [15:0]               shd_noise_gain;

    logic                      gps_enable;
    logic [NSAT-1:0][31:0]     sat_freq;
    logic [NSAT-1:0][15:0]     sat_gain;
    logic [NSAT-1:0][5:0]      sat_ca_sel;
    logic [15:0]               noise_gain;
    logic                      epoch;
    logic                      applied;
    logic                      busy;
    logic                      overrun;
    logic [31:0]               epoch_count;

    modport master (
        output run_req, commit, commit_mask, err_clr,
               shd_freq, shd_gain, shd_ca_sel, shd_noise_gain,
        input  gps_enable, sat_freq, sat_gain, sat_ca_sel, noise_gain,
               epoch, applied, busy, overrun, epoch_count
    );

    modport slave (
        input  run_req, commit, commit_mask, err_clr,
               shd_freq, shd_gain, shd_ca_sel, shd_noise_gain,
        output gps_enable, sat_freq, sat_gain, sat_ca_sel, noise_gain,
               epoch, applied, busy, overrun, epoch_count
    );
endinterface

// File: rtl/gps_epoch_sched.sv
// gps_epoch_sched: snapshots shadow channel parameters on commit and applies
// them to the emulator on the next C/A code epoch boundary.
// Optional macro GPS_EPOCH_SCHED_STATS_EN builds the epoch_count register;
// without it epoch_count reads 0.
//
// state | meaning
// IDLE  | no commit pending, accepting a new commit
// ARMED | snapshot held, waiting for the epoch to apply it
module gps_epoch_sched #(
    parameter int NSAT         = 4,
    parameter int EPOCH_CYCLES = 100000
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    gps_epoch_sched_if.slave   bus
);
    localparam int            CW       = $clog2(EPOCH_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(EPOCH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  epoch;
    logic [NSAT:0]         mask_q, mask_d;
    logic [NSAT-1:0][31:0] snap_freq_q, snap_freq_d, freq_q, freq_d;
    logic [NSAT-1:0][15:0] snap_gain_q, snap_gain_d, gain_q, gain_d;
    logic [NSAT-1:0][5:0]  snap_ca_q, snap_ca_d, ca_q, ca_d;
    logic [15:0]           snap_noise_q, snap_noise_d, noise_q, noise_d;
    logic                  gps_enable_q, gps_enable_d;
    logic                  applied_q, applied_d;
    logic                  overrun_q, overrun_d;
    logic                  overrun_set;

    assign epoch = (cnt_q == CNT_LAST);

    // Next-state: epoch counter, FSM, snapshot capture and epoch-aligned apply.
    always_comb begin
        state_d      = state_q;
        cnt_d        = epoch ? '0 : cnt_q + CW'(1);
        mask_d       = mask_q;
        snap_freq_d  = snap_freq_q;
        snap_gain_d  = snap_gain_q;
        snap_ca_d    = snap_ca_q;
        snap_noise_d = snap_noise_q;
        freq_d       = freq_q;
        gain_d       = gain_q;
        ca_d         = ca_q;
        noise_d      = noise_q;
        gps_enable_d = epoch ? bus.run_req : gps_enable_q;
        applied_d    = 1'b0;
        overrun_set  = 1'b0;

        case (state_q)
            IDLE: begin
                // Zero-mask commits are silently ignored.
                if (bus.commit && (bus.commit_mask != '0)) begin
                    mask_d       = bus.commit_mask;
                    snap_freq_d  = bus.shd_freq;
                    snap_gain_d  = bus.shd_gain;
                    snap_ca_d    = bus.shd_ca_sel;
                    snap_noise_d = bus.shd_noise_gain;
                    state_d      = ARMED;
                end
            end
            ARMED: begin
                if (epoch) begin
                    for (int i = 0; i < NSAT; i++) begin
                        if (mask_q[i]) begin
                            freq_d[i] = snap_freq_q[i];
                            gain_d[i] = snap_gain_q[i];
                            ca_d[i]   = snap_ca_q[i];
                        end
                    end
                    if (mask_q[NSAT]) begin
                        noise_d = snap_noise_q;
                    end
                    applied_d = 1'b1;
                    state_d   = IDLE;
                end
                // The pending snapshot is never replaced; a second commit is lost.
                if (bus.commit) begin
                    overrun_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (bus.err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            snap_freq_q  <= '0;
            snap_gain_q  <= '0;
            snap_ca_q    <= '0;
            snap_noise_q <= '0;
            freq_q       <= '0;
            gain_q       <= '0;
            ca_q         <= '0;
            noise_q      <= '0;
            gps_enable_q <= 1'b0;
            applied_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            snap_freq_q  <= snap_freq_d;
            snap_gain_q  <= snap_gain_d;
            snap_ca_q    <= snap_ca_d;
            snap_noise_q <= snap_noise_d;
            freq_q       <= freq_d;
            gain_q       <= gain_d;
            ca_q         <= ca_d;
            noise_q      <= noise_d;
            gps_enable_q <= gps_enable_d;
            applied_q    <= applied_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef GPS_EPOCH_SCHED_STATS_EN
    logic [31:0] epoch_count_q, epoch_count_d;

    // Epoch counter, wraps naturally at 2^32.
    always_comb begin
        epoch_count_d = epoch ? epoch_count_q + 32'd1 : epoch_count_q;
    end

    // Epoch count register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            epoch_count_q <= '0;
        end else begin
            epoch_count_q <= epoch_count_d;
        end
    end

    assign bus.epoch_count = epoch_count_q;
`else
    assign bus.epoch_count = '0;
`endif

    assign bus.gps_enable = gps_enable_q;
    assign bus.sat_freq   = freq_q;
    assign bus.sat_gain   = gain_q;
    assign bus.sat_ca_sel = ca_q;
    assign bus.noise_gain = noise_q;
    assign bus.epoch      = epoch;
    assign bus.applied    = applied_q;
    assign bus.busy       = (state_q == ARMED);
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_gps_epoch_sched.sv
// tb_gps_epoch_sched: directed test of gps_epoch_sched with NSAT=4,
// EPOCH_CYCLES=10, checked every cycle against an epoch-arithmetic model.
module tb_gps_epoch_sched;
    localparam int NSAT = 4;
    localparam int EC   = 10;
`ifdef GPS_EPOCH_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   t;

    gps_epoch_sched_if #(.NSAT(NSAT)) bus ();

    gps_epoch_sched #(.NSAT(NSAT), .EPOCH_CYCLES(EC)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    // Model: cycle t since reset release; an accepted commit in cycle tc is
    // applied at the end of the first epoch cycle strictly after tc.
    logic [31:0] m_freq  [NSAT];
    logic [15:0] m_gain  [NSAT];
    logic [5:0]  m_ca    [NSAT];
    logic [15:0] m_noise;
    logic [31:0] s_freq  [NSAT];
    logic [15:0] s_gain  [NSAT];
    logic [5:0]  s_ca    [NSAT];
    logic [15:0] s_noise;
    logic [NSAT:0] s_mask;
    bit          m_pend, m_applied, m_ov, m_en;
    int          m_apply_at;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSAT; i++) begin
                m_freq[i] = '0; m_gain[i] = '0; m_ca[i] = '0;
                chk($sformatf("rst_freq%0d", i), bus.sat_freq[i], 0);
                chk($sformatf("rst_gain%0d", i), bus.sat_gain[i], 0);
                chk($sformatf("rst_ca%0d", i),   bus.sat_ca_sel[i], 0);
            end
            m_noise = '0; m_pend = 0; m_applied = 0; m_ov = 0; m_en = 0;
            chk("rst_noise", bus.noise_gain, 0);
            chk("rst_enable", bus.gps_enable, 0);
            chk("rst_epoch", bus.epoch, 0);
            chk("rst_applied", bus.applied, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_overrun", bus.overrun, 0);
            chk("rst_epoch_count", bus.epoch_count, 0);
            t = 0;
        end else begin
            bit was_pend, ov_set;
            for (int i = 0; i < NSAT; i++) begin
                chk($sformatf("freq%0d", i), bus.sat_freq[i], m_freq[i]);
                chk($sformatf("gain%0d", i), bus.sat_gain[i], m_gain[i]);
                chk($sformatf("ca%0d", i),   bus.sat_ca_sel[i], m_ca[i]);
            end
            chk("noise", bus.noise_gain, m_noise);
            chk("enable", bus.gps_enable, m_en);
            chk("epoch", bus.epoch, (t % EC) == EC - 1);
            chk("applied", bus.applied, m_applied);
            chk("busy", bus.busy, m_pend);
            chk("overrun", bus.overrun, m_ov);
            chk("epoch_count", bus.epoch_count, STATS ? (t / EC) : 0);

            was_pend  = m_pend;
            ov_set    = 0;
            m_applied = 0;
            if (m_pend && t == m_apply_at) begin
                for (int i = 0; i < NSAT; i++) begin
                    if (s_mask[i]) begin
                        m_freq[i] = s_freq[i]; m_gain[i] = s_gain[i]; m_ca[i] = s_ca[i];
                    end
                end
                if (s_mask[NSAT]) m_noise = s_noise;
                m_applied = 1;
                m_pend    = 0;
            end
            if (bus.commit) begin
                if (was_pend) begin
                    ov_set = 1;
                end else if (bus.commit_mask != '0) begin
                    m_pend     = 1;
                    m_apply_at = ((t + 1) / EC + 1) * EC - 1;
                    s_mask     = bus.commit_mask;
                    for (int i = 0; i < NSAT; i++) begin
                        s_freq[i] = bus.shd_freq[i];
                        s_gain[i] = bus.shd_gain[i];
                        s_ca[i]   = bus.shd_ca_sel[i];
                    end
                    s_noise = bus.shd_noise_gain;
                end
            end
            if (ov_set)           m_ov = 1;
            else if (bus.err_clr) m_ov = 0;
            if ((t % EC) == EC - 1) m_en = bus.run_req;
            t++;
        end
    end

    task automatic go_to(input int target);
        int guard = 0;
        while (t != target && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (t != target) begin
            n_cmp++;
            n_err++;
            $display("FAIL go_to actual=%0d required=%0d", t, target);
        end
    endtask

    task automatic do_commit(input logic [NSAT:0] m);
        bus.commit_mask = m;
        bus.commit      = 1'b1;
        @(posedge clk); #1;
        bus.commit      = 1'b0;
        bus.commit_mask = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; t = 0;
        rst_n = 1'b0;
        bus.run_req = 0; bus.commit = 0; bus.commit_mask = '0; bus.err_clr = 0;
        bus.shd_freq = '0; bus.shd_gain = '0; bus.shd_ca_sel = '0; bus.shd_noise_gain = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset release: first epoch at cycle 9, three epochs after 30 cycles.
        go_to(8);  chk("lit_no_epoch_t8", bus.epoch, 0);
        go_to(9);  chk("lit_epoch_t9", bus.epoch, 1);
        go_to(30); chk("lit_epoch_count_t30", bus.epoch_count, STATS ? 3 : 0);

        // Commit mid-epoch on channel 2, then snapshot isolation.
        bus.shd_freq[0] = 32'hAAAA_0000;
        bus.shd_freq[2] = 32'h1234_5678;
        bus.shd_gain[2] = 16'h0123;
        bus.shd_ca_sel[2] = 6'd17;
        go_to(33);
        do_commit(5'b00100);
        bus.shd_freq[2] = 32'hFFFF_FFFF;
        chk("lit_busy_after_commit", bus.busy, 1);
        go_to(39); chk("lit_freq2_before", bus.sat_freq[2], 0);
        go_to(40);
        chk("lit_freq2_applied", bus.sat_freq[2], 32'h1234_5678);
        chk("lit_freq0_held", bus.sat_freq[0], 0);
        chk("lit_applied_pulse", bus.applied, 1);
        go_to(41); chk("lit_applied_single", bus.applied, 0);

        // Commit coincident with epoch: noise gain lands one epoch later.
        bus.shd_noise_gain = 16'h0400;
        go_to(49);
        do_commit(5'b10000);
        chk("lit_noise_not_yet", bus.noise_gain, 0);
        go_to(60); chk("lit_noise_applied", bus.noise_gain, 16'h0400);

        // Overrun: second commit dropped, err_clr loses to a new overrun.
        bus.shd_freq[0] = 32'h1111_1111;
        go_to(62); do_commit(5'b00001);
        bus.shd_freq[0] = 32'h2222_2222;
        go_to(64); do_commit(5'b00001);
        chk("lit_overrun_set", bus.overrun, 1);
        go_to(66);
        bus.err_clr = 1'b1;
        do_commit(5'b00001);
        bus.err_clr = 1'b0;
        chk("lit_overrun_set_wins", bus.overrun, 1);
        go_to(70); chk("lit_first_commit_kept", bus.sat_freq[0], 32'h1111_1111);
        go_to(72);
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        chk("lit_overrun_cleared", bus.overrun, 0);

        // Enable follows run_req only at the epoch.
        go_to(74); bus.run_req = 1'b1;
        go_to(79); chk("lit_enable_holds", bus.gps_enable, 0);
        go_to(80); chk("lit_enable_rises", bus.gps_enable, 1);

        // ARMED commit on the epoch itself: apply proceeds, new one dropped.
        bus.shd_gain[3] = 16'h7777;
        bus.shd_freq[1] = 32'h0BAD_0BAD;
        go_to(82); do_commit(5'b01000);
        go_to(89); do_commit(5'b00010);
        chk("lit_gain3_applied", bus.sat_gain[3], 16'h7777);
        chk("lit_freq1_dropped", bus.sat_freq[1], 0);
        chk("lit_overrun_on_epoch", bus.overrun, 1);

        // Reset while ARMED: outputs clear at once, nothing applied afterwards.
        bus.shd_freq = {4{32'h5555_AAAA}};
        go_to(93); do_commit(5'b11111);
        go_to(95);
        rst_n = 1'b0;
        #1 chk("lit_reset_clears_freq0", bus.sat_freq[0], 0);
        chk("lit_reset_clears_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        go_to(25);
        chk("lit_no_apply_after_reset", bus.sat_freq[3], 0);
        chk("lit_idle_after_reset", bus.busy, 0);
        chk("lit_enable_after_reset", bus.gps_enable, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
